// File: rtl/vx_bits_splice_if.sv
// Handshaked request/response bundle for the bit-field splice unit.
// The master side drives transactions in and accepts results; the slave side is the unit.
interface vx_bits_splice_if #(
  parameter int N     = 32,
  parameter int S     = 4,
  parameter int LANES = 1,
  parameter int TAGW  = 1
);
  localparam int POSW = $clog2(N + 1);

  logic                 valid_in;
  logic                 ready_in;
  logic                 mode_in;
  logic [POSW-1:0]      pos_in;
  logic [LANES*N-1:0]   data_in;
  logic [LANES*S-1:0]   ins_in;
  logic [TAGW-1:0]      tag_in;

  logic                 valid_out;
  logic                 ready_out;
  logic [LANES*N-1:0]   data_out;
  logic                 err_out;
  logic [TAGW-1:0]      tag_out;

  modport master (
    output valid_in, mode_in, pos_in, data_in, ins_in, tag_in, ready_out,
    input  ready_in, valid_out, data_out, err_out, tag_out
  );

  modport slave (
    input  valid_in, mode_in, pos_in, data_in, ins_in, tag_in, ready_out,
    output ready_in, valid_out, data_out, err_out, tag_out
  );
endinterface

// File: rtl/vx_bits_splice.sv
// Two-stage streaming bit-field splice: removes or inserts an S-bit field at a
// runtime position in each of LANES N-bit words, with position clamping and
// full valid/ready backpressure.
module vx_bits_splice #(
  parameter int N     = 32,
  parameter int S     = 4,
  parameter int LANES = 1,
  parameter int TAGW  = 1
) (
  input logic             clk,
  input logic             reset,
  vx_bits_splice_if.slave bus
);
  localparam int              POSW = $clog2(N + 1);
  localparam logic [POSW-1:0] MAXP = POSW'(N - S);
  localparam logic [N-1:0]    ONES = '1;

  // Stage 1 state
  logic                 s1_valid;
  logic                 s1_mode;
  logic                 s1_err;
  logic [POSW-1:0]      s1_pos;
  logic [N-1:0]         s1_mask;
  logic [LANES*N-1:0]   s1_data;
  logic [LANES*S-1:0]   s1_ins;
  logic [TAGW-1:0]      s1_tag;

  logic                 s1_adv;
  logic                 pos_over;
  logic [POSW-1:0]      pos_eff;
  logic [LANES*N-1:0]   s2_data;

  // Handshake chain and input position clamp
  always_comb begin
    s1_adv       = s1_valid && (!bus.valid_out || bus.ready_out);
    bus.ready_in = !s1_valid || s1_adv;
    pos_over     = bus.pos_in > MAXP;
    pos_eff      = pos_over ? MAXP : bus.pos_in;
  end

  // Stage 1: capture accepted transaction with clamped position and low-keep mask
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_err   <= 1'b0;
      s1_pos   <= '0;
      s1_mask  <= '0;
      s1_data  <= '0;
      s1_ins   <= '0;
      s1_tag   <= '0;
    end else if (bus.ready_in) begin
      s1_valid <= bus.valid_in;
      if (bus.valid_in) begin
        s1_mode <= bus.mode_in;
        s1_err  <= pos_over;
        s1_pos  <= pos_eff;
        s1_mask <= ~(ONES << pos_eff);
        s1_data <= bus.data_in;
        s1_ins  <= bus.ins_in;
        s1_tag  <= bus.tag_in;
      end
    end
  end

  // Stage 2 datapath: masked merge of the shifted terms, per lane.
  // Insert's upper part is (d & ~mask) << S, which places d[i-S] at every i >= p+S.
  always_comb begin
    s2_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (s1_mode) begin
        s2_data[k*N +: N] = (s1_data[k*N +: N] & s1_mask)
                          | (N'(s1_ins[k*S +: S]) << s1_pos)
                          | ((s1_data[k*N +: N] & ~s1_mask) << S);
      end else begin
        s2_data[k*N +: N] = (s1_data[k*N +: N] & s1_mask)
                          | ((s1_data[k*N +: N] >> S) & ~s1_mask);
      end
    end
  end

  // Stage 2 output registers: load on S1 advance, hold while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.err_out   <= 1'b0;
      bus.tag_out   <= '0;
    end else if (s1_adv) begin
      bus.valid_out <= 1'b1;
      bus.data_out  <= s2_data;
      bus.err_out   <= s1_err;
      bus.tag_out   <= s1_tag;
    end else if (bus.ready_out) begin
      bus.valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vx_bits_splice.sv
// Bench for vx_bits_splice (N=32, S=4, LANES=2, TAGW=4): table vectors, latency,
// backpressure and mid-stream reset, with a queue scoreboard and a bit-level model.
module tb_vx_bits_splice;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vx_bits_splice_if #(.N(32), .S(4), .LANES(2), .TAGW(4)) bus ();

  vx_bits_splice #(.N(32), .S(4), .LANES(2), .TAGW(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic        mode;
    logic [5:0]  pos;
    logic [31:0] d0, d1;
    logic [3:0]  i0, i1;
    logic [31:0] e0, e1;
    logic        err;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t next_exp;
  bit   prev_stall = 0;
  logic [63:0] prev_data;
  logic [3:0]  prev_tag;
  bit   saw_drop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model written bit-by-bit from the field definitions
  function automatic exp_t model(input logic mode, input logic [5:0] pos,
                                 input logic [63:0] d, input logic [7:0] ins,
                                 input logic [3:0] tag);
    exp_t r;
    int p;
    logic [31:0] dw, o;
    logic [3:0] iw;
    p = (pos > 6'd28) ? 28 : int'(pos);
    r.err = (pos > 6'd28);
    r.tag = tag;
    r.data = '0;
    for (int l = 0; l < 2; l++) begin
      dw = d[l*32 +: 32];
      iw = ins[l*4 +: 4];
      for (int i = 0; i < 32; i++) begin
        if (i < p) o[i] = dw[i];
        else if (!mode) o[i] = (i < 28) ? dw[i+4] : 1'b0;
        else if (i < p + 4) o[i] = iw[i-p];
        else o[i] = dw[i-4];
      end
      r.data[l*32 +: 32] = o;
    end
    return r;
  endfunction

  // One clock cycle, entered and left at a falling edge with inputs already set
  task automatic cycle(output bit acc);
    bit con;
    exp_t e;
    #1;
    acc = bus.valid_in && bus.ready_in;
    con = bus.valid_out && bus.ready_out;
    if (prev_stall) begin
      chk("stall_valid_hold", 64'(bus.valid_out), 64'd1);
      chk("stall_data_hold", bus.data_out, prev_data);
      chk("stall_tag_hold", 64'(bus.tag_out), 64'(prev_tag));
    end
    if (bus.valid_in && !bus.ready_in) begin
      saw_drop = 1;
      chk("ready_in_drop_buffered", 64'(q.size()), 64'd2);
    end
    if (con) begin
      if (q.size() == 0) chk("unexpected_output", 64'(bus.tag_out), 64'hFFFF);
      else begin
        e = q.pop_front();
        chk("sb_data", bus.data_out, e.data);
        chk("sb_err", 64'(bus.err_out), 64'(e.err));
        chk("sb_tag", 64'(bus.tag_out), 64'(e.tag));
      end
    end
    if (acc) q.push_back(next_exp);
    prev_stall = bus.valid_out && !bus.ready_out;
    prev_data  = bus.data_out;
    prev_tag   = bus.tag_out;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    while (q.size() > 0 && n < 50) begin
      cycle(acc);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    prev_stall = 0;
  endtask

  // Single transaction with explicit cycle-by-cycle latency checks
  task automatic latency(input string nm, input logic mode, input logic [5:0] pos,
                         input logic [63:0] d, input logic [7:0] ins);
    exp_t e;
    e = model(mode, pos, d, ins, 4'd9);
    bus.valid_in = 1'b1; bus.mode_in = mode; bus.pos_in = pos;
    bus.data_in = d; bus.ins_in = ins; bus.tag_in = 4'd9; bus.ready_out = 1'b1;
    #1 chk({nm, "_ready_in"}, 64'(bus.ready_in), 64'd1);
    @(posedge clk); @(negedge clk);
    bus.valid_in = 1'b0;
    chk({nm, "_valid_t1"}, 64'(bus.valid_out), 64'd0);
    @(posedge clk); @(negedge clk);
    chk({nm, "_valid_t2"}, 64'(bus.valid_out), 64'd1);
    chk({nm, "_data"}, bus.data_out, e.data);
    chk({nm, "_err"}, 64'(bus.err_out), 64'(e.err));
    @(posedge clk); @(negedge clk);
    chk({nm, "_consumed"}, 64'(bus.valid_out), 64'd0);
  endtask

  initial begin
    vec_t tbl[8];
    bit   acc;
    int   sent, c, n;
    logic [63:0] rd;
    logic [7:0]  ri;

    tbl[0] = '{1'b0, 6'd0,  32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 4'h0, 32'h0DEADBEE, 32'h0DEADBEE, 1'b0};
    tbl[1] = '{1'b0, 6'd28, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 4'h0, 32'h0EADBEEF, 32'h0EADBEEF, 1'b0};
    tbl[2] = '{1'b0, 6'd30, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 4'h0, 32'h0EADBEEF, 32'h0EADBEEF, 1'b1};
    tbl[3] = '{1'b1, 6'd8,  32'h12345678, 32'h12345678, 4'hA, 4'hA, 32'h23456A78, 32'h23456A78, 1'b0};
    tbl[4] = '{1'b1, 6'd0,  32'h12345678, 32'h12345678, 4'h5, 4'h5, 32'h23456785, 32'h23456785, 1'b0};
    tbl[5] = '{1'b1, 6'd4,  32'h0000FFFF, 32'hFFFF0000, 4'h0, 4'hF, 32'h000FFF0F, 32'hFFF000F0, 1'b0};
    tbl[6] = '{1'b1, 6'd63, 32'h12345678, 32'h12345678, 4'hA, 4'hA, 32'hA2345678, 32'hA2345678, 1'b1};
    tbl[7] = '{1'b0, 6'd16, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 4'h0, 32'h0DEABEEF, 32'h0DEABEEF, 1'b0};

    bus.valid_in = 1'b0; bus.mode_in = 1'b0; bus.pos_in = '0; bus.data_in = '0;
    bus.ins_in = '0; bus.tag_in = '0; bus.ready_out = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_data_out", bus.data_out, 64'd0);
    chk("rst_err_out", 64'(bus.err_out), 64'd0);
    chk("rst_tag_out", 64'(bus.tag_out), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_in", 64'(bus.ready_in), 64'd1);

    // First-transaction latency
    latency("lat", 1'b0, 6'd0, 64'hDEADBEEF_DEADBEEF, 8'h00);

    // Table vectors streamed back to back
    for (int i = 0; i < 8; i++) begin
      bus.valid_in = 1'b1; bus.mode_in = tbl[i].mode; bus.pos_in = tbl[i].pos;
      bus.data_in = {tbl[i].d1, tbl[i].d0}; bus.ins_in = {tbl[i].i1, tbl[i].i0};
      bus.tag_in = 4'(i); bus.ready_out = 1'b1;
      next_exp.data = {tbl[i].e1, tbl[i].e0};
      next_exp.err  = tbl[i].err;
      next_exp.tag  = 4'(i);
      acc = 0; n = 0;
      while (!acc && n < 10) begin cycle(acc); n++; end
      chk("tbl_accept", 64'(acc), 64'd1);
    end
    drain();

    // Backpressure: 6 tagged transactions, ready_out low for cycles 3..7
    sent = 0; c = 0; saw_drop = 0;
    while ((sent < 6 || q.size() > 0) && c < 60) begin
      rd = {$urandom(), $urandom()};
      ri = 8'($urandom());
      bus.valid_in = (sent < 6); bus.mode_in = 1'($urandom());
      bus.pos_in = 6'($urandom_range(0, 33)); bus.data_in = rd; bus.ins_in = ri;
      bus.tag_in = 4'(sent);
      bus.ready_out = !(c >= 3 && c <= 7);
      next_exp = model(bus.mode_in, bus.pos_in, rd, ri, 4'(sent));
      cycle(acc);
      if (acc) sent++;
      c++;
    end
    chk("bp_all_sent", 64'(sent), 64'd6);
    chk("bp_saw_ready_drop", 64'(saw_drop), 64'd1);
    drain();

    // Reset with two transactions in flight
    bus.ready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.valid_in = 1'b1; bus.mode_in = 1'b1; bus.pos_in = 6'd4;
      bus.data_in = 64'hFFFFFFFF_FFFFFFFF; bus.ins_in = 8'h00; bus.tag_in = 4'(10 + i);
      next_exp = model(1'b1, 6'd4, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 4'(10 + i));
      cycle(acc);
    end
    bus.valid_in = 1'b0;
    chk("pre_rst_valid", 64'(bus.valid_out), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.valid_out), 64'd0);
    chk("async_rst_data", bus.data_out, 64'd0);
    chk("async_rst_tag", 64'(bus.tag_out), 64'd0);
    q.delete();
    prev_stall = 0;
    @(negedge clk);
    reset = 1'b1;
    bus.ready_out = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_in", 64'(bus.ready_in), 64'd1);
    chk("post_rst_no_output", 64'(bus.valid_out), 64'd0);
    latency("post_rst", 1'b1, 6'd8, 64'h12345678_0000FFFF, 8'h3A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
